// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: frame-synchronous round-robin sharing of a 4-digit seven-segment display.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always lit).
module seg_display_scheduler #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_A_IN,
    input  logic [15:0] VALUE_A_IN,
    input  logic [3:0]  DOT_A_IN,
    input  logic        REQ_B_IN,
    input  logic [15:0] VALUE_B_IN,
    input  logic [3:0]  DOT_B_IN,
    output logic        GNT_A_OUT,
    output logic        GNT_B_OUT,
    output logic [1:0]  SEG_SELECT_OUT,
    output logic [3:0]  BIN_OUT,
    output logic        DOT_OUT,
    output logic        BLANK_OUT,
    output logic        FRAME_OUT
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d, sel_q, sel_d;
    logic [15:0]   disp_q, disp_d;
    logic [3:0]    dots_q, dots_d, bin_q, bin_d;
    logic          last_b_q, last_b_d, dot_q, dot_d, blank_q, blank_d;
    logic          tc, boundary, win_a, win_b;

    always_comb begin
        tc       = cnt_q == CW'(REFRESH_DIV - 1);
        boundary = RESET && tc && idx_q == 2'd3;
        win_a    = boundary && REQ_A_IN && (!REQ_B_IN || last_b_q);
        win_b    = boundary && REQ_B_IN && (!REQ_A_IN || !last_b_q);
        cnt_d    = tc ? '0 : cnt_q + CW'(1);
        idx_d    = tc ? idx_q + 2'd1 : idx_q;
        disp_d   = win_a ? VALUE_A_IN : win_b ? VALUE_B_IN : disp_q;
        dots_d   = win_a ? DOT_A_IN : win_b ? DOT_B_IN : dots_q;
        last_b_d = win_b || (last_b_q && !win_a);
        // Output registers load from next-state so they track the digit that is about to show.
`ifdef LEADING_ZERO_BLANK_EN
        blank_d  = idx_d != 2'd0 && (disp_d >> {idx_d, 2'b00}) == 16'd0;
`else
        blank_d  = 1'b0;
`endif
        sel_d    = idx_d;
        bin_d    = disp_d[{idx_d, 2'b00} +: 4];
        dot_d    = dots_d[idx_d] && !blank_d;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            disp_q   <= 16'h0000;
            dots_q   <= 4'h0;
            last_b_q <= 1'b1;
            sel_q    <= 2'd0;
            bin_q    <= 4'h0;
            dot_q    <= 1'b0;
            blank_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
            dots_q   <= dots_d;
            last_b_q <= last_b_d;
            sel_q    <= sel_d;
            bin_q    <= bin_d;
            dot_q    <= dot_d;
            blank_q  <= blank_d;
        end
    end

    assign GNT_A_OUT      = win_a;
    assign GNT_B_OUT      = win_b;
    assign FRAME_OUT      = boundary;
    assign SEG_SELECT_OUT = sel_q;
    assign BIN_OUT        = bin_q;
    assign DOT_OUT        = dot_q;
    assign BLANK_OUT      = blank_q;
endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb_seg_display_scheduler: scoreboard bench for seg_display_scheduler with REFRESH_DIV=4.
module tb_seg_display_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [15:0] val_a = '0, val_b = '0;
    logic [3:0]  dot_a = '0, dot_b = '0;
    logic        gnt_a, gnt_b, dot_o, blank_o, frame_o;
    logic [1:0]  sel_o;
    logic [3:0]  bin_o;

    typedef struct {
        logic        b;
        logic [15:0] v;
        logic [3:0]  d;
    } gexp_t;

    gexp_t       sb[$];
    gexp_t       e;
    int          n_chk = 0, n_err = 0;
    int          pos = 0;
    logic [15:0] exp_val = '0;
    logic [3:0]  exp_dot = '0;
    logic        bl;

    seg_display_scheduler #(.REFRESH_DIV(4)) dut (
        .CLK(clk), .RESET(rst_n),
        .REQ_A_IN(req_a), .VALUE_A_IN(val_a), .DOT_A_IN(dot_a),
        .REQ_B_IN(req_b), .VALUE_B_IN(val_b), .DOT_B_IN(dot_b),
        .GNT_A_OUT(gnt_a), .GNT_B_OUT(gnt_b), .SEG_SELECT_OUT(sel_o),
        .BIN_OUT(bin_o), .DOT_OUT(dot_o), .BLANK_OUT(blank_o), .FRAME_OUT(frame_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic exp_blank(input logic [15:0] v, input int d);
        bit z;
        z = d != 0;
        for (int k = d; k < 4; k++) if (v[4*k +: 4] != 4'h0) z = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        return z;
`else
        return 1'b0 & z;
`endif
    endfunction

    // Monitor: pos is the cycle's place in the 16-cycle frame from the spec's timeline.
    always @(negedge clk) begin
        bl = exp_blank(exp_val, pos / 4);
        chk("frame", int'(frame_o), int'(pos == 15 && rst_n));
        chk("sel", int'(sel_o), pos / 4);
        chk("bin", int'(bin_o), int'(exp_val[4*(pos/4) +: 4]));
        chk("dot", int'(dot_o), int'(exp_dot[pos/4] && !bl));
        chk("blank", int'(blank_o), int'(bl));
        if (gnt_a || gnt_b) begin
            chk("gnt_pos", pos, 15);
            if (sb.size() == 0) chk("gnt_unexp", int'({gnt_a, gnt_b}), 0);
            else begin
                e = sb.pop_front();
                chk("gnt_who", int'({gnt_a, gnt_b}), e.b ? 1 : 2);
                exp_val = e.v;
                exp_dot = e.d;
            end
        end
        pos = !rst_n ? 0 : (pos + 1) % 16;
        if (!rst_n) begin
            exp_val = '0;
            exp_dot = '0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int p);
        step();
        for (int i = 0; i < 40 && pos != p; i++) step();
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) step();
        chk("sb_drain", sb.size(), 0);
    endtask

    task automatic grant_a(input logic [15:0] v, input logic [3:0] d, input int at);
        wait_pos(at);
        val_a = v;
        dot_a = d;
        req_a = 1'b1;
        sb.push_back('{1'b0, v, d});
        drain();
        req_a = 1'b0;
        repeat (20) step();
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        repeat (34) step();
        grant_a(16'h1234, 4'b0100, 5);
        grant_a(16'h0050, 4'b1111, 3);
        grant_a(16'h0000, 4'b0001, 2);
        // B pulses mid-frame and drops before any boundary
        wait_pos(4);
        val_b = 16'hDEAD;
        dot_b = 4'hF;
        req_b = 1'b1;
        repeat (3) step();
        req_b = 1'b0;
        repeat (20) step();
        // Reset asserted in the boundary cycle with A requesting
        grant_a(16'h5678, 4'b1010, 6);
        val_a = 16'h9999;
        wait_pos(14);
        req_a = 1'b1;
        wait_pos(15);
        rst_n = 1'b0;
        step();
        chk("rst_sel", int'(sel_o), 0);
        chk("rst_bin", int'(bin_o), 0);
        chk("rst_gnt", int'({gnt_a, gnt_b}), 0);
        rst_n = 1'b1;
        req_a = 1'b0;
        repeat (20) step();
        // Contention after reset: A wins the first tie, then alternate
        wait_pos(5);
        val_a = 16'hAAAA;
        dot_a = 4'b0001;
        val_b = 16'hBBBB;
        dot_b = 4'b1000;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < 4; i++)
            sb.push_back(i % 2 == 0 ? '{1'b0, 16'hAAAA, 4'b0001} : '{1'b1, 16'hBBBB, 4'b1000});
        drain();
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (20) step();
        chk("sb_final", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
